// File: rtl/sync_filter_bank.sv
// Multi-channel synchroniser with per-channel polarity, runtime glitch filter and rise/fall pulses.
// Define SYNC_FILTER_STICKY_EN to add per-channel sticky edge status (status_clr / edge_status).
module sync_filter_bank #(
    parameter int                  CHANNELS    = 8,
    parameter int                  SYNC_STAGES = 3,
    parameter int                  FILTER_BITS = 4,
    parameter logic [CHANNELS-1:0] INVERT_MASK = '1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CHANNELS-1:0]    async_in,
    input  logic [FILTER_BITS-1:0] filter_len,
`ifdef SYNC_FILTER_STICKY_EN
    input  logic [CHANNELS-1:0]    status_clr,
    output logic [CHANNELS-1:0]    edge_status,
`endif
    output logic [CHANNELS-1:0]    level_out,
    output logic [CHANNELS-1:0]    rise_pulse,
    output logic [CHANNELS-1:0]    fall_pulse,
    output logic                   changed
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("sync_filter_bank: SYNC_STAGES must be in 2..4");
    end

    localparam logic [FILTER_BITS-1:0] CNT_ONE = FILTER_BITS'(1);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0]    sync_q;
    logic [CHANNELS-1:0]                     logic_lvl;
    logic [CHANNELS-1:0][FILTER_BITS-1:0]    cnt_q, cnt_d;
    logic [CHANNELS-1:0]                     level_q, level_d;
    logic [CHANNELS-1:0]                     rise_q, rise_d;
    logic [CHANNELS-1:0]                     fall_q, fall_d;
    logic                                    changed_q, changed_d;

    // Reset preloads each chain with its idle raw level so release never looks like an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{INVERT_MASK}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign logic_lvl = sync_q[SYNC_STAGES-1] ^ INVERT_MASK;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (logic_lvl[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= filter_len) begin
                level_d[i] = logic_lvl[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        rise_d    = level_d & ~level_q;
        fall_d    = ~level_d & level_q;
        changed_d = |(rise_d | fall_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            level_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign changed    = changed_q;

`ifdef SYNC_FILTER_STICKY_EN
    logic [CHANNELS-1:0] status_q, status_d;

    // A pulse in flight beats a coincident clear.
    always_comb begin
        status_d = (status_q & ~status_clr) | rise_q | fall_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign edge_status = status_q;
`endif

endmodule

// File: tb/tb_sync_filter_bank.sv
// Scoreboard bench for sync_filter_bank: directed stimulus queues expected pulse events,
// a negedge monitor pops and compares them whenever the DUT shows a pulse.
module tb_sync_filter_bank;

    logic       clock;
    logic       reset;
    logic [7:0] async_in;
    logic [3:0] filter_len;
    logic [7:0] level_out;
    logic [7:0] rise_pulse;
    logic [7:0] fall_pulse;
    logic       changed;
`ifdef SYNC_FILTER_STICKY_EN
    logic [7:0] status_clr;
    logic [7:0] edge_status;
`endif

    sync_filter_bank #(
        .CHANNELS   (8),
        .SYNC_STAGES(3),
        .FILTER_BITS(4),
        .INVERT_MASK(8'hFF)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .async_in   (async_in),
        .filter_len (filter_len),
`ifdef SYNC_FILTER_STICKY_EN
        .status_clr (status_clr),
        .edge_status(edge_status),
`endif
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .changed    (changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] level;
        logic [7:0] rise;
        logic [7:0] fall;
    } evt_t;

    evt_t       exp_q[$];
    evt_t       mon_e;
    logic [7:0] cur_level = 8'h00;
    bit         mon_en    = 1'b0;
    int         n_checks  = 0;
    int         n_fail    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_evt(input int c, input logic [7:0] lvl, input logic [7:0] r,
                              input logic [7:0] f);
        evt_t e;
        e.cyc   = c;
        e.level = lvl;
        e.rise  = r;
        e.fall  = f;
        exp_q.push_back(e);
    endtask

    // Inputs change 2 time units after a rising edge; the next edge (cyc+1) samples them.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    // Monitor: any pulse or changed cycle must match the head of the expected queue.
    always @(negedge clock) begin
        if (reset) begin
            cur_level = 8'h00;
        end else if (mon_en) begin
            if (changed || (rise_pulse != 8'h00) || (fall_pulse != 8'h00)) begin
                if (exp_q.size() == 0) begin
                    check("spurious_event", {15'd0, changed, rise_pulse, fall_pulse}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("evt_cycle", cyc, mon_e.cyc);
                    check("evt_rise", 32'(rise_pulse), 32'(mon_e.rise));
                    check("evt_fall", 32'(fall_pulse), 32'(mon_e.fall));
                    check("evt_level", 32'(level_out), 32'(mon_e.level));
                    check("evt_changed", 32'(changed), 32'd1);
                    cur_level = mon_e.level;
                end
            end else begin
                check("idle_level", 32'(level_out), 32'(cur_level));
            end
        end
    end

    int k;

    initial begin
        reset      = 1'b1;
        async_in   = 8'hFF;
        filter_len = 4'd0;
`ifdef SYNC_FILTER_STICKY_EN
        status_clr = 8'h00;
`endif
        // 1. Reset state, then 20 quiet cycles with idle inputs.
        step(2);
        reset = 1'b0;
        check("rst_level", 32'(level_out), 32'h00);
        check("rst_rise", 32'(rise_pulse), 32'h00);
        check("rst_fall", 32'(fall_pulse), 32'h00);
        check("rst_changed", 32'(changed), 32'h0);
        mon_en = 1'b1;
        step(20);

        // 2. Latency with filter_len 0 and 7.
        filter_len = 4'd0;
        async_in[0] = 1'b0; k = cyc + 1;
        expect_evt(k + 3, 8'h01, 8'h01, 8'h00);
        step(8);
        async_in[0] = 1'b1; k = cyc + 1;
        expect_evt(k + 3, 8'h00, 8'h00, 8'h01);
        step(8);
        filter_len = 4'd7;
        async_in[0] = 1'b0; k = cyc + 1;
        expect_evt(k + 10, 8'h01, 8'h01, 8'h00);
        step(15);
        async_in[0] = 1'b1; k = cyc + 1;
        expect_evt(k + 10, 8'h00, 8'h00, 8'h01);
        step(15);

        // 3. Glitch boundary at filter_len 5: 5 low cycles rejected, 6 accepted.
        filter_len = 4'd5;
        async_in[3] = 1'b0;
        step(5);
        async_in[3] = 1'b1;
        step(12);
        async_in[3] = 1'b0; k = cyc + 1;
        expect_evt(k + 8, 8'h08, 8'h08, 8'h00);
        expect_evt(k + 14, 8'h00, 8'h00, 8'h08);
        step(6);
        async_in[3] = 1'b1;
        step(20);

        // 4. All channels at once.
        filter_len = 4'd2;
        async_in = 8'h00; k = cyc + 1;
        expect_evt(k + 5, 8'hFF, 8'hFF, 8'h00);
        step(10);
        async_in = 8'hFF; k = cyc + 1;
        expect_evt(k + 5, 8'h00, 8'h00, 8'hFF);
        step(10);

        // 5. Reset after 5 counted cycles discards the count.
        filter_len = 4'd10;
        async_in[1] = 1'b0; k = cyc + 1;
        step(8);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst_mid_level1", 32'(level_out[1]), 32'd0);
        check("rst_mid_rise", 32'(rise_pulse), 32'h00);
        k = cyc + 1;
        expect_evt(k + 13, 8'h02, 8'h02, 8'h00);
        step(20);
        async_in[1] = 1'b1; k = cyc + 1;
        expect_evt(k + 13, 8'h00, 8'h00, 8'h02);
        step(20);

`ifdef SYNC_FILTER_STICKY_EN
        // 6. Sticky status: set after pulse, clear, set wins over coincident clear.
        filter_len = 4'd0;
        status_clr = 8'hFF;
        step(1);
        status_clr = 8'h00;
        check("sticky_cleared", 32'(edge_status), 32'h00);
        async_in[2] = 1'b0; k = cyc + 1;
        expect_evt(k + 3, 8'h04, 8'h04, 8'h00);
        step(4);
        check("sticky_not_yet", 32'(edge_status), 32'h00);
        step(1);
        check("sticky_set", 32'(edge_status), 32'h04);
        step(2);
        status_clr[2] = 1'b1;
        step(1);
        status_clr[2] = 1'b0;
        check("sticky_clr", 32'(edge_status), 32'h00);
        async_in[2] = 1'b1; k = cyc + 1;
        expect_evt(k + 3, 8'h00, 8'h00, 8'h04);
        step(4);
        status_clr[2] = 1'b1;
        step(1);
        status_clr[2] = 1'b0;
        check("sticky_set_wins", 32'(edge_status), 32'h04);
        step(5);
`endif

        step(5);
        check("pending_events", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_filter_bank.md
Name: sync_filter_bank

Overview:
Multi-channel successor to the single-bit synchroniser. Brings CHANNELS asynchronous inputs into the clock domain through a parametrised-depth flop chain, with optional per-channel polarity inversion. A runtime-programmable glitch filter follows, and the block emits registered one-cycle rise/fall pulses. It sits between the padframe/actuator feedback inputs and the controller logic; one instance replaces many single-bit synchronisers.

Parameters:
- CHANNELS, 8: number of independent input channels.
- SYNC_STAGES, 3: synchroniser flops per channel. Legal range 2..4; any other value is an elaboration error.
- FILTER_BITS, 4: width of the filter_len input and of each per-channel filter counter.
- INVERT_MASK, all ones (CHANNELS bits): bit i = 1 means channel i is active-low; logical level = raw XOR INVERT_MASK[i].

Ports:
- clock  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- async_in  input  CHANNELS  raw asynchronous inputs.
- filter_len  input  FILTER_BITS  stability requirement in cycles, quasi-static, shared by all channels.
- level_out  output  CHANNELS  filtered logical level (1 = asserted).
- rise_pulse  output  CHANNELS  one-cycle pulse when level_out[i] goes 0->1.
- fall_pulse  output  CHANNELS  one-cycle pulse when level_out[i] goes 1->0.
- changed  output  1  registered OR of all rise_pulse and fall_pulse bits.

Behaviour:
- One clock and one reset: reset is synchronous and active-high. Only the clock and reset ports are clocking/reset inputs.
- Reset values:
  - Sync chain of channel i loaded with its idle raw level: 1 if INVERT_MASK[i], else 0.
  - Filter counters = 0.
  - level_out, rise_pulse, fall_pulse, changed = 0.
- Reset mid-operation: all state returns to reset values at that edge. In-progress counts are discarded and no pulse is generated by reset.
- Sync stage: raw bit shifts through SYNC_STAGES flops each cycle. The last flop output s[i] is the only value used downstream. l[i] = s[i] XOR INVERT_MASK[i].
- Filter, per channel, each cycle:
  - If l == level_out: counter <= 0.
  - Else if counter >= filter_len: level_out <= l and counter <= 0.
  - Else: counter <= counter + 1.
  - The counter never exceeds filter_len, so no wrap-around is possible.
- Latency: a raw change first sampled at edge k reaches level_out at edge k + SYNC_STAGES + filter_len, provided the raw level stays stable.
- Glitch rejection:
  - A synced mismatch lasting <= filter_len cycles is discarded: counter clears, level_out unchanged, no pulses.
  - A mismatch lasting >= filter_len+1 cycles is accepted.
- filter_len = 0 means no filtering: pure synchroniser plus 1 register stage.
- filter_len reduced mid-count: because the compare is >=, an in-progress counter at or above the new value updates on the next edge.
- Pulses are registered and coincident with the level_out transition: rise_pulse[i] = 1 in the first cycle level_out[i] reads 1, for exactly one cycle. fall_pulse behaves the same way for 1->0.
- rise_pulse[i] and fall_pulse[i] are never both 1.
- changed is asserted in the same cycle as any pulse.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses and a single changed cycle.

Optional Feature:
- Macro: SYNC_FILTER_STICKY_EN.
- Defined:
  - Adds input status_clr [CHANNELS] and output edge_status [CHANNELS].
  - edge_status[i] is set in the cycle after rise_pulse[i] or fall_pulse[i] is 1.
  - It is cleared at the edge where status_clr[i] = 1.
  - Set wins if set and clear occur together.
  - Reset value 0.
- Undefined: both ports and all associated storage are absent; the rest of the behaviour is identical.

Test Plan (CHANNELS=8, SYNC_STAGES=3, FILTER_BITS=4, INVERT_MASK=8'hFF):
1. Reset: async_in=8'hFF, reset high for 2 edges, then low for 20 cycles -> level_out=8'h00; rise_pulse, fall_pulse and changed stay 0 throughout.
2. Latency: filter_len=0, async_in[0] 1->0 before edge k and held -> level_out[0]=1 and rise_pulse[0]=1 at edge k+3, for one cycle. Repeat with filter_len=7 -> transition at edge k+10.
3. Glitch boundary: filter_len=5; async_in[3] low for 5 cycles -> no change, no pulses. Low for 6 cycles -> level_out[3] rises at k+8, then falls 6 cycles later with fall_pulse[3] for one cycle.
4. Simultaneous: filter_len=2, async_in 8'hFF->8'h00 at one edge -> rise_pulse=8'hFF and changed=1 in the same single cycle.
5. Reset mid-count: filter_len=10, async_in[1] low; reset asserted for 1 cycle after 5 counted cycles -> no pulse, level_out[1]=0. Input held low -> rise at reset release + 13 edges.
6. Sticky (macro defined): rise on ch2 -> edge_status[2]=1 the next cycle. status_clr[2]=1 -> cleared. status_clr[2] coincident with a new fall_pulse[2] -> edge_status[2] remains 1.
